jtgng_rom_arb: RTL
==================

# jtgng_rom_arb

Round-robin arbiter that shares the single read port of `jtgng_sdram` between up to SLOTS ROM requesters: main CPU, sound CPU, char, scroll and object fetchers. It sits between `jt1943_game`'s ROM clients and the SDRAM controller. Each slot keeps a one-entry tagged data register, so a repeated address is served without an SDRAM access. It also opens refresh windows and aborts all activity during ROM download.

## Interface
- `SLOTS`, 4: number of requesters (2..8).
- `AW`, 22: SDRAM word address width.
- `DW`, 32: read data width.
- `WDOG_W`, 8: watchdog counter width (only used with the macro).

Ports:
- `clk` in 1: system clock, 48 MHz.
- `rst` in 1: synchronous, active-high reset.
- `downloading` in 1: ROM download in progress; treated like reset for the arbiter state.
- `slot_cs` in SLOTS: per-slot request level.
- `slot_addr` in SLOTS*AW: flat address vector; slot i occupies bits [i*AW +: AW].
- `slot_ok` out SLOTS: slot_dout is valid for the current slot_addr.
- `slot_dout` out SLOTS*DW: per-slot data, flat vector.
- `sdram_req` out 1: read request, held until sdram_ack.
- `sdram_addr` out AW: address of the active read.
- `sdram_ack` in 1: one-cycle pulse; the request has been accepted.
- `data_rdy` in 1: one-cycle pulse; data_read is valid.
- `data_read` in DW: SDRAM read data.
- `refresh_en` out 1: SDRAM controller may refresh.
- `loop_rst` out 1: controller loop reset, = rst | downloading (registered).
- `wdog_err` out 1: sticky timeout flag. Reads 0 when JTGNG_ROMARB_WDOG_EN is undefined.

## Operation
- Per slot, the block keeps `tag[i]` (AW bits), `data[i]` (DW bits) and `valid[i]`.
- Hit: `hit[i] = valid[i] & tag[i]==slot_addr[i]`.
- Output: `slot_ok[i] = slot_cs[i] & hit[i]`, combinational.
- Pending: `pend[i] = slot_cs[i] & ~hit[i]`.
- FSM states are IDLE, WAIT_ACK and WAIT_DATA.
- IDLE:
  - If any pend bit is set, grant the first pending slot searching upward from `last+1`, wrapping modulo SLOTS.
  - On grant, register `sel`, `last<=sel`, `sdram_addr<=slot_addr[sel]`, `sdram_req<=1`, and go to WAIT_ACK.
- WAIT_ACK: on sdram_ack, `sdram_req<=0` and go to WAIT_DATA.
- WAIT_DATA: on data_rdy, `data[sel]<=data_read`, `tag[sel]<=sdram_addr`, `valid[sel]<=1`, and go to IDLE.
- The tag is the address latched at grant, not the live address. If a requester changes its address mid-fetch, it gets the data but no false ok; its new address becomes pending again.
- `slot_cs` dropping mid-fetch does not abort the read; the fetch still completes and fills the slot.
- `sdram_ack` and `data_rdy` in the same cycle while in WAIT_ACK: store the data and return to IDLE.
- `refresh_en`: registered `(state==IDLE) & ~|pend`.
- rst or downloading forces IDLE, `sdram_req=0`, `valid=0`, `last=SLOTS-1`, and `wdog_err=0` on rst only. The same applies when these arrive mid-operation; any in-flight data_rdy is ignored.

## Timing
- Reset values:
  - `sdram_req=0`, `sdram_addr=0`, `refresh_en=0`, `loop_rst=1`, `wdog_err=0`.
  - `slot_dout=0`, `slot_ok=0` (all valid bits cleared).
- Miss latency:
  - cs or new address at cycle 0, with the arbiter idle: sdram_req is high at cycle 1.
  - data_rdy at cycle N: slot_ok is high at cycle N+1.
- Hit: slot_ok responds in the same cycle (zero latency).
- Back-to-back: a new grant is possible in the cycle after data_rdy, because the FSM is in IDLE at N+1.
- Fairness: with all slots pending, grant order is cyclic, and any slot waits at most SLOTS-1 fetches.

## Configuration
- `JTGNG_ROMARB_WDOG_EN` defined:
  - A WDOG_W counter runs in WAIT_ACK and WAIT_DATA and clears on every state change.
  - At all-ones, the block drops sdram_req, returns to IDLE without filling, and sets `wdog_err` (sticky until rst).
- `JTGNG_ROMARB_WDOG_EN` undefined: no counter, the FSM waits indefinitely, and `wdog_err` is tied to 0.

## Structure
- `jtgng_rom_arb_pkg` holds:
  - the state enum type `romarb_st_t` (IDLE, WAIT_ACK, WAIT_DATA);
  - the round-robin search function `rr_next(pend, last)`.
- One sub-module, `jtgng_rom_arb_slot`, instantiated SLOTS times. It holds tag, data and valid, does the hit compare, and has a fill strobe input.
- The top level holds the FSM, the round-robin pointer and the watchdog.

## Test plan
- After reset, slot0 cs with addr 0x000100 → sdram_req=1 and sdram_addr=0x000100 one cycle later. Ack, then data_rdy with 0xDEADBEEF → slot_ok[0]=1 and slot_dout[0]=0xDEADBEEF on the next cycle.
- Repeat slot0 at 0x000100 → slot_ok[0]=1 in the same cycle, and sdram_req stays 0.
- All 4 slots pending with distinct addresses and last=3 → grants in order 0,1,2,3. Re-raise slot0 after its fill with a new address → it is granted only after slot3.
- Slot1 address changes from 0x10 to 0x20 during WAIT_DATA → no slot_ok[1] for 0x20 after the fill; a second request to 0x20 is issued.
- downloading pulsed during WAIT_DATA → sdram_req=0, the FSM is IDLE, all slot_ok=0, and a late data_rdy is ignored.
- With WDOG_EN and WDOG_W=8: no ack for 255 cycles → sdram_req drops, wdog_err=1, and the next pending slot is granted.

Source files
------------

// File: rtl/jtgng_rom_arb_pkg.sv
// jtgng_rom_arb_pkg: shared FSM state type and round-robin search for the ROM arbiter
package jtgng_rom_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} romarb_st_t;
  // First set bit of pend searching upward from last+1, wrapping at slots; last itself has lowest priority.
  function automatic logic [2:0] rr_next(input logic [7:0] pend, input logic [2:0] last, input int slots);
    logic [2:0] r;
    logic [2:0] idx;
    r = last;
    for (int k = slots; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % slots);
      if (pend[idx]) r = idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/jtgng_rom_arb_slot.sv
// jtgng_rom_arb_slot: one-entry tagged data register for a single ROM requester
// Ports: clk/rst (rst also covers download), fill strobe with fill_addr/fill_data,
//        live addr/cs from the requester, hit/ok flags and held data dout.
module jtgng_rom_arb_slot #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic          ok,
  output logic [DW-1:0] dout
);
  logic          valid;
  logic [AW-1:0] tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      dout  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      dout  <= fill_data;
    end
  end
  assign hit = valid && tag == addr;
  assign ok  = cs && hit;
endmodule

// File: rtl/jtgng_rom_arb.sv
// jtgng_rom_arb: round-robin arbiter sharing the SDRAM read port among SLOTS ROM clients
// Ports: clk, rst, downloading; per-slot slot_cs/slot_addr in, slot_ok/slot_dout out;
//        SDRAM side sdram_req/sdram_addr out, sdram_ack/data_rdy/data_read in;
//        refresh_en, loop_rst, wdog_err out. Watchdog enabled by JTGNG_ROMARB_WDOG_EN.
module jtgng_rom_arb
  import jtgng_rom_arb_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int AW     = 22,
  parameter int DW     = 32,
  parameter int WDOG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en,
  output logic                loop_rst,
  output logic                wdog_err
);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  romarb_st_t        st, st_nxt;
  logic              clr, fill, timeout;
  logic [SW-1:0]     sel, last, gnt;
  logic [SLOTS-1:0]  hit, pend;
  logic [AW-1:0]     addr_a [SLOTS];
  logic [WDOG_W-1:0] wdog_cnt;
  assign clr  = rst || downloading;
  assign pend = slot_cs & ~hit;
  assign gnt  = SW'(rr_next(8'(pend), 3'(last), SLOTS));
  // Data arriving together with the ack is accepted as well.
  assign fill = data_rdy && (st == WAIT_DATA || (st == WAIT_ACK && sdram_ack));
  assign timeout = st != IDLE && &wdog_cnt && !fill;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_a[i] = slot_addr[i*AW +: AW];
    jtgng_rom_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk,
      .rst       (clr),
      .fill      (fill && sel == SW'(i)),
      .fill_addr (sdram_addr),
      .fill_data (data_read),
      .cs        (slot_cs[i]),
      .addr      (addr_a[i]),
      .hit       (hit[i]),
      .ok        (slot_ok[i]),
      .dout      (slot_dout[i*DW +: DW])
    );
  end
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:      st_nxt = |pend ? WAIT_ACK : IDLE;
      WAIT_ACK:  st_nxt = sdram_ack ? (data_rdy ? IDLE : WAIT_DATA) : WAIT_ACK;
      WAIT_DATA: st_nxt = data_rdy ? IDLE : WAIT_DATA;
      default:   st_nxt = IDLE;
    endcase
    if (timeout) st_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel        <= '0;
      last       <= SW'(SLOTS-1);
      refresh_en <= 1'b0;
    end else begin
      st         <= st_nxt;
      refresh_en <= st == IDLE && !(|pend);
      if (st == IDLE && |pend) begin
        sel        <= gnt;
        last       <= gnt;
        sdram_addr <= addr_a[gnt];
        sdram_req  <= 1'b1;
      end
      if (st == WAIT_ACK && (sdram_ack || timeout)) sdram_req <= 1'b0;
    end
  end
  always_ff @(posedge clk) loop_rst <= clr;
`ifdef JTGNG_ROMARB_WDOG_EN
  always_ff @(posedge clk) begin
    if (clr || st == IDLE || st_nxt != st) wdog_cnt <= '0;
    else wdog_cnt <= wdog_cnt + WDOG_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) wdog_err <= 1'b0;
    else if (timeout && !downloading) wdog_err <= 1'b1;
  end
`else
  assign wdog_cnt = '0;
  assign wdog_err = 1'b0;
`endif
endmodule
